// File: rtl/sd_matrix_parser_pkg.sv
// Shared types and constants for the SD sector matrix parser.
package sd_matrix_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TAG   = 3'd1,
    ST_PARSE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned DEF_SECTOR_BYTES = 512;
  localparam int unsigned DEF_N_ELEMS      = 32;
  localparam int unsigned DEF_ELEM_W       = 8;
  localparam logic [63:0] DEF_TAG          = 64'h4D41_5458_5F54_4147; // "MATX_TAG"

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_TAB   = 8'h09;

  // Byte idx of the tag, byte 0 being the most significant.
  function automatic logic [7:0] tag_byte(input logic [63:0] tag, input logic [2:0] idx);
    logic [63:0] sh;
    sh = tag >> {3'd7 - idx, 3'd0};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/sd_matrix_parser_hex_char_decode.sv
// Classifies one ASCII byte as hex digit (with its value) and/or token separator.
module hex_char_decode
  import sd_matrix_parser_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic       is_hex,
  output logic [3:0] nibble,
  output logic       is_sep
);

  // Hex digit detection and value.
  always_comb begin
    is_hex = 1'b1;
    nibble = 4'd0;
    if (in_byte >= 8'h30 && in_byte <= 8'h39) begin
      nibble = in_byte[3:0];
    end else if ((in_byte >= 8'h41 && in_byte <= 8'h46) ||
                 (in_byte >= 8'h61 && in_byte <= 8'h66)) begin
      nibble = in_byte[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
      nibble = 4'd0;
    end
  end

  // Separator detection.
  always_comb begin
    case (in_byte)
      CH_SP, CH_CR, CH_LF, CH_COMMA, CH_TAB: is_sep = 1'b1;
      default:                               is_sep = 1'b0;
    endcase
  end

endmodule

// File: rtl/sd_matrix_parser.sv
// Consumes one SD sector per start pulse: checks the leading tag, then captures
// whitespace-separated hex tokens into a small element register file.
module sd_matrix_parser
  import sd_matrix_parser_pkg::*;
#(
  parameter int unsigned SECTOR_BYTES = DEF_SECTOR_BYTES,
  parameter int unsigned N_ELEMS      = DEF_N_ELEMS,
  parameter int unsigned ELEM_W       = DEF_ELEM_W,
  parameter logic [63:0] TAG          = DEF_TAG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              busy,
  output logic              done,
  output logic              tag_ok,
  output logic              parse_ok,
  output logic [5:0]        elem_count,
  output logic              bad_char,
  input  logic [4:0]        rd_idx,
  output logic [ELEM_W-1:0] rd_data
);

  localparam logic [9:0] LAST_IDX = 10'(SECTOR_BYTES - 1);
  localparam logic [5:0] FULL_CNT = 6'(N_ELEMS);

  state_e            state_q, state_d;
  logic [9:0]        byte_cnt_q, byte_cnt_d;
  logic [ELEM_W-1:0] elem_q [N_ELEMS];
  logic [ELEM_W-1:0] elem_d [N_ELEMS];
  logic [5:0]        elem_count_q, elem_count_d;
  logic              bad_char_q, bad_char_d;
  logic              tag_ok_q, tag_ok_d;
  logic              parse_ok_q, parse_ok_d;
  logic [ELEM_W-1:0] acc_q, acc_d;
  logic              tok_active_q, tok_active_d;
  logic              tag_match_q, tag_match_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              is_hex_s, is_sep_s, last_s, fin_s;
  logic [3:0]        nibble_s;

  hex_char_decode u_decode (
    .in_byte (in_byte),
    .is_hex  (is_hex_s),
    .nibble  (nibble_s),
    .is_sep  (is_sep_s)
  );

  // Next-state and datapath update for one accepted byte.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    elem_d       = elem_q;
    elem_count_d = elem_count_q;
    bad_char_d   = bad_char_q;
    tag_ok_d     = tag_ok_q;
    parse_ok_d   = parse_ok_q;
    acc_d        = acc_q;
    tok_active_d = tok_active_q;
    tag_match_d  = tag_match_q;
    last_s       = 1'b0;
    fin_s        = 1'b0;
    if (start) begin
      state_d      = ST_TAG;
      byte_cnt_d   = 10'd0;
      elem_d       = '{default: '0};
      elem_count_d = 6'd0;
      bad_char_d   = 1'b0;
      tag_ok_d     = 1'b0;
      parse_ok_d   = 1'b0;
      acc_d        = '0;
      tok_active_d = 1'b0;
      tag_match_d  = 1'b1;
    end else begin
      case (state_q)
        ST_TAG, ST_PARSE, ST_DRAIN: begin
          if (in_valid) begin
            byte_cnt_d = byte_cnt_q + 10'd1;
            last_s     = (byte_cnt_q == LAST_IDX);
            case (state_q)
              ST_TAG: begin
                tag_match_d = tag_match_q & (in_byte == tag_byte(TAG, byte_cnt_q[2:0]));
                state_d     = (byte_cnt_q == 10'd7) ? (tag_match_d ? ST_PARSE : ST_DRAIN) : ST_TAG;
              end
              ST_PARSE: begin
                if (is_hex_s) begin
                  acc_d        = ELEM_W'({acc_q, nibble_s});
                  tok_active_d = 1'b1;
                end else begin
                  bad_char_d   = bad_char_q | ~is_sep_s;
                end
                // A token ends on any non-hex byte, or on the sector's final byte.
                fin_s = tok_active_d & (~is_hex_s | last_s);
                if (fin_s) begin
                  elem_d[elem_count_q[4:0]] = acc_d;
                  elem_count_d = elem_count_q + 6'd1;
                  acc_d        = '0;
                  tok_active_d = 1'b0;
                  state_d      = (elem_count_d == FULL_CNT) ? ST_DRAIN : ST_PARSE;
                end else begin
                  state_d      = ST_PARSE;
                end
              end
              default: state_d = state_q;
            endcase
            state_d    = last_s ? ST_DONE : state_d;
            tag_ok_d   = last_s ? tag_match_d : tag_ok_q;
            parse_ok_d = last_s ? (tag_match_d & (elem_count_d == FULL_CNT) & ~bad_char_d)
                                : parse_ok_q;
          end else begin
            state_d = state_q;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_TAG) || (state_d == ST_PARSE) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= 10'd0;
      elem_q       <= '{default: '0};
      elem_count_q <= 6'd0;
      bad_char_q   <= 1'b0;
      tag_ok_q     <= 1'b0;
      parse_ok_q   <= 1'b0;
      acc_q        <= '0;
      tok_active_q <= 1'b0;
      tag_match_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      elem_q       <= elem_d;
      elem_count_q <= elem_count_d;
      bad_char_q   <= bad_char_d;
      tag_ok_q     <= tag_ok_d;
      parse_ok_q   <= parse_ok_d;
      acc_q        <= acc_d;
      tok_active_q <= tok_active_d;
      tag_match_q  <= tag_match_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign tag_ok     = tag_ok_q;
  assign parse_ok   = parse_ok_q;
  assign elem_count = elem_count_q;
  assign bad_char   = bad_char_q;
  assign rd_data    = elem_q[rd_idx];

endmodule

// File: tb/tb_sd_matrix_parser.sv
// Bench for sd_matrix_parser: sector-level reference model plus per-cycle compare.
module tb_sd_matrix_parser;

  localparam int SB = 512;
  typedef logic [7:0] sector_t [SB];
  typedef struct packed {
    logic            tag_ok;
    logic            bad;
    logic [5:0]      count;
    logic [31:0][7:0] elems;
  } result_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic [4:0] rd_idx = 5'd0;
  logic       busy, done, tag_ok, parse_ok, bad_char;
  logic [5:0] elem_count;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_pass = 0;

  sector_t sec;

  sd_matrix_parser dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .busy       (busy),
    .done       (done),
    .tag_ok     (tag_ok),
    .parse_ok   (parse_ok),
    .elem_count (elem_count),
    .bad_char   (bad_char),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int hexval(input logic [7:0] c);
    int ic;
    ic = int'(c);
    if (ic >= 48 && ic <= 57) return ic - 48;
    if (ic >= 65 && ic <= 70) return ic - 55;
    if (ic >= 97 && ic <= 102) return ic - 87;
    return -1;
  endfunction

  function automatic bit is_separator(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h0D) || (c == 8'h0A) || (c == 8'h2C) || (c == 8'h09);
  endfunction

  // Whole-sector interpretation; last is the byte at offset SB-1.
  function automatic result_t ref_parse(input sector_t s, input logic [7:0] last);
    result_t r;
    string   t;
    int      acc, cnt;
    bit      act;
    logic [7:0] c;
    t = "MATX_TAG";
    r = '0;
    r.tag_ok = 1'b1;
    acc = 0; cnt = 0; act = 1'b0;
    for (int i = 0; i < 8; i++) if (s[i] != t[i]) r.tag_ok = 1'b0;
    if (!r.tag_ok) return r;
    for (int i = 8; i < SB && cnt < 32; i++) begin
      c = (i == SB - 1) ? last : s[i];
      if (hexval(c) >= 0) begin
        acc = (acc * 16 + hexval(c)) % 256;
        act = 1'b1;
      end else begin
        if (!is_separator(c)) r.bad = 1'b1;
        if (act) begin
          r.elems[cnt] = acc[7:0];
          cnt++;
          acc = 0;
          act = 1'b0;
        end
      end
    end
    if (act && cnt < 32) begin
      r.elems[cnt] = acc[7:0];
      cnt++;
    end
    r.count = 6'(cnt);
    return r;
  endfunction

  // Reference model: tracks valid-byte count per sector and the latched results.
  sector_t m_bytes;
  int      m_cnt;
  logic    m_busy, m_done;
  result_t m_res;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (start) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (m_busy && in_valid) begin
      m_bytes[m_cnt] <= in_byte;
      m_cnt <= m_cnt + 1;
      if (m_cnt == SB - 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= ref_parse(m_bytes, in_byte);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("tag_ok", tag_ok, m_res.tag_ok);
    check("parse_ok", parse_ok, m_res.tag_ok && m_res.count == 6'd32 && !m_res.bad);
    if (!m_busy) begin
      check("elem_count", elem_count, m_res.count);
      check("bad_char", bad_char, m_res.bad);
      check("rd_data", rd_data, m_res.elems[rd_idx]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_str(input int pos, input string s);
    for (int i = 0; i < s.len(); i++) sec[pos + i] = s[i];
  endtask

  task automatic fill(input logic [7:0] b);
    for (int i = 0; i < SB; i++) sec[i] = b;
  endtask

  task automatic put_crlf(input int pos);
    sec[pos]     = 8'h0D;
    sec[pos + 1] = 8'h0A;
  endtask

  task automatic build_std(input int ntok);
    fill(8'h00);
    put_str(0, "MATX_TAG");
    put_crlf(8);
    for (int k = 1; k <= ntok; k++) begin
      put_str(10 + (k - 1) * 4, $sformatf("%02X", k));
      put_crlf(12 + (k - 1) * 4);
    end
  endtask

  task automatic build_rand(input int bad_pct, input int hex_pct, input bit bad_tag);
    string hx;
    logic [7:0] seps [5];
    logic [7:0] bads [4];
    int r;
    hx = "0123456789ABCDEFabcdef";
    seps = '{8'h20, 8'h0D, 8'h0A, 8'h2C, 8'h09};
    bads = '{8'h67, 8'h5A, 8'h21, 8'h00};
    put_str(0, "MATX_TAG");
    if (bad_tag) sec[$urandom_range(0, 7)] = 8'h3F;
    for (int i = 8; i < SB; i++) begin
      r = $urandom_range(0, 99);
      if (r < bad_pct) sec[i] = bads[$urandom_range(0, 3)];
      else if (r < bad_pct + hex_pct) sec[i] = hx[$urandom_range(0, 21)];
      else sec[i] = seps[$urandom_range(0, 4)];
    end
  endtask

  task automatic send_start();
    start = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'h4D;
    step();
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  // gap: 0 back-to-back, N>0 one valid byte every N cycles, <0 random gaps.
  task automatic feed(input int from, input int to, input int gap);
    int idle;
    for (int i = from; i < to; i++) begin
      idle = (gap < 0) ? int'($urandom_range(0, 2)) : ((gap > 0) ? gap - 1 : 0);
      repeat (idle) begin
        in_valid = 1'b0;
        in_byte = 8'($urandom);
        rd_idx = 5'($urandom);
        step();
      end
      in_valid = 1'b1;
      in_byte = sec[i];
      rd_idx = 5'($urandom);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic idle_junk(input int n);
    repeat (n) begin
      in_valid = 1'($urandom);
      in_byte = 8'($urandom);
      rd_idx = 5'($urandom);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic run(input int gap);
    send_start();
    feed(0, SB, gap);
    idle_junk(4);
  endtask

  task automatic pin_rd(input string name, input logic [4:0] idx, input logic [7:0] exp);
    rd_idx = idx;
    #1;
    check(name, rd_data, exp);
  endtask

  task automatic pin_full_ok(input string tag);
    check({tag, " tag_ok"}, tag_ok, 1);
    check({tag, " parse_ok"}, parse_ok, 1);
    check({tag, " elem_count"}, elem_count, 32);
    check({tag, " bad_char"}, bad_char, 0);
    pin_rd({tag, " rd0"}, 5'd0, 8'h01);
    pin_rd({tag, " rd31"}, 5'd31, 8'h20);
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst tag_ok", tag_ok, 0);
    check("rst elem_count", elem_count, 0);
    pin_rd("rst rd7", 5'd7, 8'h00);

    build_std(32);
    run(0);
    pin_full_ok("std");

    build_std(32);
    sec[3] = 8'h59;
    run(0);
    check("badtag tag_ok", tag_ok, 0);
    check("badtag parse_ok", parse_ok, 0);
    check("badtag elem_count", elem_count, 0);
    pin_rd("badtag rd5", 5'd5, 8'h00);

    build_std(30);
    for (int i = 130; i < SB; i++) sec[i] = 8'h20;
    sec[510] = 8'h46;
    sec[511] = 8'h46;
    run(0);
    check("tok31 elem_count", elem_count, 31);
    check("tok31 parse_ok", parse_ok, 0);
    check("tok31 tag_ok", tag_ok, 1);
    pin_rd("tok31 rd30", 5'd30, 8'hFF);
    pin_rd("tok31 rd29", 5'd29, 8'h1E);

    fill(8'h20);
    put_str(0, "MATX_TAG");
    put_crlf(8);
    put_str(10, "1A3 g5 ");
    run(-1);
    check("badch bad_char", bad_char, 1);
    check("badch elem_count", elem_count, 2);
    check("badch parse_ok", parse_ok, 0);
    pin_rd("badch rd0", 5'd0, 8'hA3);
    pin_rd("badch rd1", 5'd1, 8'h05);

    build_std(32);
    run(3);
    pin_full_ok("gap3");

    build_rand(2, 50, 1'b0);  run(-1);
    build_rand(0, 2, 1'b0);   run(0);
    build_rand(1, 40, 1'b1);  run(3);
    build_rand(0, 60, 1'b0);  run(-1);

    build_std(32);
    send_start();
    feed(0, 200, 0);
    send_start();
    feed(0, 100, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort tag_ok", tag_ok, 0);
    check("abort parse_ok", parse_ok, 0);
    check("abort elem_count", elem_count, 0);
    check("abort bad_char", bad_char, 0);
    pin_rd("abort rd0", 5'd0, 8'h00);
    pin_rd("abort rd3", 5'd3, 8'h00);
    idle_junk(20);

    build_std(32);
    run(0);
    pin_full_ok("post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_matrix_parser.md
Name: sd_matrix_parser

Overview:
- Streaming parser between the SD-card controller byte output (dout/sd_valid) and the matrix-multiply/print stage.
- Consumes exactly one 512-byte sector per start pulse.
- Checks the 8-byte ASCII tag "MATX_TAG" at sector offset 0, then parses whitespace-separated hex tokens into a 32-entry element register file (matrix A row-major in entries 0..15, matrix B row-major in 16..31).
- Replaces the ad-hoc SRAM-readback decoding; the multiplier reads elements through a random-access read port.

Parameters:
- SECTOR_BYTES, 512, bytes consumed per sector before done.
- N_ELEMS, 32, number of elements to capture.
- ELEM_W, 8, element width in bits; tokens accumulate 4 bits per hex digit, keep low ELEM_W bits.
- TAG, "MATX_TAG" (64 bits), tag compared at offsets 0..7, byte 0 in TAG[63:56].

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse: begin new sector (aligned with SD rd_req)
- in_valid  in  1  in_byte valid this cycle (SD sd_valid)
- in_byte  in  8  sector byte
- busy  out  1  high from cycle after start until done
- done  out  1  one-cycle pulse after last sector byte
- tag_ok  out  1  tag matched; valid from done until next start
- parse_ok  out  1  tag_ok && elem_count==N_ELEMS && !bad_char; valid with tag_ok
- elem_count  out  6  elements captured so far (saturates at N_ELEMS)
- bad_char  out  1  sticky: non-hex, non-separator byte seen in parse region
- rd_idx  in  5  element read index
- rd_data  out  ELEM_W  element[rd_idx], combinational read

Behaviour:
- Reset: state IDLE; busy=0, done=0, tag_ok=0, parse_ok=0, elem_count=0, bad_char=0; all elements 0; byte counter 0.
- States: IDLE, TAG, PARSE, DRAIN, DONE.
- IDLE: on start -> TAG; clear byte_cnt, elements, elem_count, bad_char, tag_ok, parse_ok, token accumulator; set tag_match=1.
- Bytes count only on in_valid. byte_cnt increments per valid byte, 10 bits.
- TAG: compare in_byte with TAG byte byte_cnt; mismatch clears tag_match. After byte 7 -> PARSE if tag_match else DRAIN.
- PARSE, per valid byte:
  - hex digit (0-9, A-F, a-f): acc <= (acc<<4)|nibble, truncated to ELEM_W; set tok_active.
  - separator (0x20, 0x0D, 0x0A, 0x2C, 0x09): if tok_active, write acc to element[elem_count], elem_count++, clear acc/tok_active.
  - any other byte: set bad_char; treated as separator.
  - when elem_count reaches N_ELEMS -> DRAIN; remaining bytes ignored.
- DRAIN: count bytes only.
- In any busy state, the valid byte with byte_cnt==SECTOR_BYTES-1 is the last:
  - if in PARSE with tok_active and elem_count<N_ELEMS, finalize that token on the same edge.
  - next state DONE.
- DONE: done=1 for one cycle; tag_ok and parse_ok latch; -> IDLE.
- tag_ok, parse_ok, elem_count, elements and bad_char hold until next start.
- Latency: done asserts exactly 1 cycle after the clock edge that accepts the last byte.
- start while busy: abort current sector, restart as from IDLE (same clearing); no done for the aborted sector.
- start coincident with in_valid: the byte is ignored; the first counted byte is the first valid after start.
- in_valid in IDLE/DONE: ignored.
- Reset mid-sector: immediate IDLE, all outputs to reset values.
- Tag mismatch: elements stay 0, elem_count=0; done still pulses after 512 bytes with tag_ok=0.

Decomposition:
- Shared package holds:
  - state enum;
  - TAG default constant;
  - character constants CR, LF, SP, COMMA, TAB;
  - SECTOR_BYTES default.
- Sub-module hex_char_decode, purely combinational: in_byte -> is_hex, nibble[3:0], is_sep.

Test Plan:
- "MATX_TAG\r\n" followed by 32 tokens "01".."20" (hex), one per CRLF, zero-padded to 512 bytes -> done at 1 cycle after byte 511; tag_ok=1, parse_ok=1, elem_count=32; rd_idx=0 -> 0x01, rd_idx=31 -> 0x20.
- Byte 3 = "Y" (tag "MATY_TAG"), otherwise valid -> done after 512 bytes; tag_ok=0, parse_ok=0, elem_count=0, rd_data=0 for all idx.
- Valid tag, only 31 tokens, last token "FF" ending at byte 511 with no separator -> final token captured; elem_count=31, element[30]=0xFF, parse_ok=0.
- Token "1A3" and token "g5" in the parse region -> element = 0xA3; bad_char=1; "g" treated as separator; next element = 0x05; parse_ok=0.
- in_valid toggling every 3rd cycle across the full sector -> identical results to the back-to-back case; done only after the 512th valid byte.
- start re-pulsed at byte 200, then reset asserted at byte 100 of the restarted sector -> no done pulse is produced; all outputs return to reset values the cycle after reset.
